ram_ctrl_bw: RTL and testbench

- Parametrised single-port synchronous data RAM with a request/ready handshake, per-byte write enables and a configurable 1- or 2-cycle read latency.
- Includes a hardware clear engine that zero-fills the array after reset and on command.
- Drop-in data-memory successor for the 16-bit RISC datapath. The storage array is inferred inside the block, so no vendor core is needed.

---
 rtl/ram_ctrl_pkg.sv | 18 +
 rtl/ram_sp_bw_array.sv | 49 ++++
 rtl/ram_ctrl_bw.sv | 164 ++++++++++++++++
 tb/tb_ram_ctrl_bw.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the byte-write data RAM controller.
// Holds the FSM state encoding, the legal read latencies and the lane-count helper.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  function automatic int unsigned lane_count(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_sp_bw_array.sv
// Inferred single-port RAM with per-byte write enables and a registered read port.
// Out-of-range writes are dropped and out-of-range reads return zero.
module ram_sp_bw_array
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we_i,
  input  logic [lane_count(DATA_W)-1:0] be_i,
  input  logic                          re_i,
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic [DATA_W-1:0]             rdata_o
);

  localparam int unsigned NB = lane_count(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              in_range;

  assign in_range = (32'(addr_i) < DEPTH);

  // Storage itself has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (be_i[i]) begin
          mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= in_range ? mem[addr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_ctrl_bw.sv
// Data RAM controller: req/ready handshake, byte writes, 1- or 2-cycle reads,
// and a clear engine that zero-fills the array after reset and on clr_req.
module ram_ctrl_bw
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req,
  input  logic                          we,
  input  logic [lane_count(DATA_W)-1:0] be,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             din,
  input  logic                          clr_req,
  output logic                          ready,
  output logic                          rvalid,
  output logic [DATA_W-1:0]             dout,
  output logic                          busy
);

  localparam int unsigned NB = lane_count(DATA_W);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("RD_LAT must be 1 or 2");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of 8");
  end
  if (DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("DEPTH exceeds address space");
  end

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [RD_LAT-1:0] vld_q, vld_d;

  logic              accept, rd_acc, cnt_last;
  logic              mem_we;
  logic [NB-1:0]     mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rdata;

  assign accept   = req && ready_q;
  assign rd_acc   = accept && !we;
  assign cnt_last = (32'(cnt_q) == DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
    end
  end

  // The clear engine borrows the array port, which is safe because ready is low
  // for the whole of DRAIN and CLEAR, so no user access can collide with it.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    mem_we    = accept && we;
    mem_be    = be;
    mem_addr  = addr;
    mem_wdata = din;

    if (clr_req && (state_q == IDLE)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (vld_q == '0) begin
          state_d = CLEAR;
          pend_d  = 1'b0;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_be    = '1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE) && !pend_d;
    busy_d  = (state_d != IDLE);
  end

  if (RD_LAT == 1) begin : g_lat1
    always_comb begin
      vld_d = rd_acc;
    end
    assign dout = rdata;
  end else begin : g_lat2
    logic [DATA_W-1:0] dout_q;

    always_comb begin
      vld_d = {vld_q[0], rd_acc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (vld_q[0]) begin
        dout_q <= rdata;
      end
    end

    assign dout = dout_q;
  end

  ram_sp_bw_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .be_i    (mem_be),
    .re_i    (rd_acc),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (rdata)
  );

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign rvalid = vld_q[RD_LAT-1];

endmodule

// File: tb/tb_ram_ctrl_bw.sv
// Bench for ram_ctrl_bw: RD_LAT=1 and RD_LAT=2 instances share one stimulus stream,
// and each has its own scoreboard of expected read data and arrival cycle.
module tb_ram_ctrl_bw;

  localparam int DEPTH = 256;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  be;
  logic [7:0]  addr;
  logic [15:0] din;
  logic        clr_req;

  logic        ready1, rvalid1, busy1;
  logic [15:0] dout1;
  logic        ready2, rvalid2, busy2;
  logic [15:0] dout2;

  int   total;
  int   bad;
  int   cyc;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1;
  exp_t e2;

  ram_ctrl_bw #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEPTH), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .din(din),
    .clr_req(clr_req), .ready(ready1), .rvalid(rvalid1), .dout(dout1), .busy(busy1)
  );

  ram_ctrl_bw #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEPTH), .RD_LAT(2), .CLEAR_ON_RESET(1)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .din(din),
    .clr_req(clr_req), .ready(ready2), .rvalid(rvalid2), .dout(dout2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the RD_LAT=1 instance: pop on every rvalid, flag late or missing data.
  always @(negedge clk) begin
    if (rvalid1 === 1'b1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("[TB] FAIL rd_lat1_unexpected: rvalid with dout=%h, no read outstanding", dout1);
      end else begin
        e1 = q1.pop_front();
        if (dout1 !== e1.data || cyc !== e1.due) begin
          bad++;
          $display("[TB] FAIL rd_lat1: dout=%h at cycle %0d, wanted %h at cycle %0d", dout1, cyc, e1.data, e1.due);
        end
      end
    end else if (q1.size() > 0 && q1[0].due < cyc) begin
      total++;
      bad++;
      $display("[TB] FAIL rd_lat1_missing: no rvalid by cycle %0d, wanted %h at cycle %0d", cyc, q1[0].data, q1[0].due);
      void'(q1.pop_front());
    end
  end

  // Scoreboard for the RD_LAT=2 instance.
  always @(negedge clk) begin
    if (rvalid2 === 1'b1) begin
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("[TB] FAIL rd_lat2_unexpected: rvalid with dout=%h, no read outstanding", dout2);
      end else begin
        e2 = q2.pop_front();
        if (dout2 !== e2.data || cyc !== e2.due) begin
          bad++;
          $display("[TB] FAIL rd_lat2: dout=%h at cycle %0d, wanted %h at cycle %0d", dout2, cyc, e2.data, e2.due);
        end
      end
    end else if (q2.size() > 0 && q2[0].due < cyc) begin
      total++;
      bad++;
      $display("[TB] FAIL rd_lat2_missing: no rvalid by cycle %0d, wanted %h at cycle %0d", cyc, q2[0].data, q2[0].due);
      void'(q2.pop_front());
    end
  end

  // Called at a negedge; returns at the first negedge where both instances are ready.
  task automatic waitReady();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (ready1 === 1'b1 && ready2 === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL ready_timeout: ready1=%b ready2=%b, wanted both 1", ready1, ready2);
    end
  endtask

  task automatic driveWrite(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
    req  = 1'b1;
    we   = 1'b1;
    addr = a;
    din  = d;
    be   = b;
  endtask

  task automatic driveRead(input logic [7:0] a, input logic [15:0] expd);
    req  = 1'b1;
    we   = 1'b0;
    addr = a;
    q1.push_back('{expd, cyc + 1});
    q2.push_back('{expd, cyc + 2});
  endtask

  task automatic idleBus();
    req = 1'b0;
    we  = 1'b0;
  endtask

  task automatic doWrite(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
    waitReady();
    driveWrite(a, d, b);
    @(negedge clk);
    idleBus();
  endtask

  task automatic doRead(input logic [7:0] a, input logic [15:0] expd);
    waitReady();
    driveRead(a, expd);
    @(negedge clk);
    idleBus();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int r1;
    int r2;
    rst_n   = 1'b1;
    idleBus();
    be      = 2'b00;
    addr    = '0;
    din     = '0;
    clr_req = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total += 4;
    if (ready1 !== 1'b0 || ready2 !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_ready: %b/%b, wanted 0/0", ready1, ready2);
    end
    if (rvalid1 !== 1'b0 || rvalid2 !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_rvalid: %b/%b, wanted 0/0", rvalid1, rvalid2);
    end
    if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_busy: %b/%b, wanted 0/0", busy1, busy2);
    end
    if (dout1 !== 16'h0000 || dout2 !== 16'h0000) begin
      bad++; $display("[TB] FAIL reset_dout: %h/%h, wanted 0000/0000", dout1, dout2);
    end

    rst_n = 1'b1;
    r1 = -1;
    r2 = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (n == 128) begin
        total++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1 || ready1 !== 1'b0) begin
          bad++; $display("[TB] FAIL reset_clear_busy: busy=%b/%b ready=%b, wanted busy 1/1 ready 0", busy1, busy2, ready1);
        end
      end
      if (ready1 === 1'b1 && r1 < 0) r1 = n;
      if (ready2 === 1'b1 && r2 < 0) r2 = n;
      if (r1 >= 0 && r2 >= 0) break;
    end
    total += 2;
    if (r1 != DEPTH) begin
      bad++; $display("[TB] FAIL reset_clear_len_lat1: ready after %0d cycles, wanted %0d", r1, DEPTH);
    end
    if (r2 != DEPTH) begin
      bad++; $display("[TB] FAIL reset_clear_len_lat2: ready after %0d cycles, wanted %0d", r2, DEPTH);
    end

    waitReady();
    driveRead(8'd0, 16'h0000);
    @(negedge clk);
    driveRead(8'd128, 16'h0000);
    @(negedge clk);
    driveRead(8'd255, 16'h0000);
    @(negedge clk);
    idleBus();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_byte_write();
    doWrite(8'h10, 16'hABCD, 2'b11);
    doWrite(8'h10, 16'h1234, 2'b01);
    doRead(8'h10, 16'hAB34);
    doWrite(8'h10, 16'h9900, 2'b00);
    doRead(8'h10, 16'hAB34);
    doWrite(8'h10, 16'h5600, 2'b10);
    doRead(8'h10, 16'h5634);
  endtask

  task automatic test_write_read_next();
    waitReady();
    driveWrite(8'd3, 16'h5A5A, 2'b11);
    @(negedge clk);
    driveRead(8'd3, 16'h5A5A);
    @(negedge clk);
    idleBus();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    doWrite(8'd1, 16'h0001, 2'b11);
    doWrite(8'd2, 16'h0002, 2'b11);
    doWrite(8'd3, 16'h0003, 2'b11);
    waitReady();
    for (int i = 1; i <= 3; i++) begin
      a = 8'(i);
      driveRead(a, 16'(i));
      @(negedge clk);
      total++;
      if (ready1 !== 1'b1 || ready2 !== 1'b1) begin
        bad++; $display("[TB] FAIL stream_ready_%0d: %b/%b, wanted 1/1", i, ready1, ready2);
      end
    end
    idleBus();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clear_collision();
    int r1;
    int r2;
    doWrite(8'd5, 16'h00FF, 2'b11);
    waitReady();
    driveRead(8'd5, 16'h00FF);
    clr_req = 1'b1;
    @(negedge clk);
    idleBus();
    clr_req = 1'b0;
    total++;
    if (ready1 !== 1'b0 || ready2 !== 1'b0) begin
      bad++; $display("[TB] FAIL clr_ready_drop: %b/%b, wanted 0/0", ready1, ready2);
    end
    r1 = -1;
    r2 = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      clr_req = (n == 50);
      if (ready1 === 1'b1 && r1 < 0) r1 = n;
      if (ready2 === 1'b1 && r2 < 0) r2 = n;
      if (r1 >= 0 && r2 >= 0) break;
    end
    clr_req = 1'b0;
    total += 2;
    if (r1 != 2 + DEPTH) begin
      bad++; $display("[TB] FAIL clr_len_lat1: ready after %0d cycles, wanted %0d", r1, 2 + DEPTH);
    end
    if (r2 != 3 + DEPTH) begin
      bad++; $display("[TB] FAIL clr_len_lat2: ready after %0d cycles, wanted %0d", r2, 3 + DEPTH);
    end
    repeat (10) @(negedge clk);
    total++;
    if (ready1 !== 1'b1 || ready2 !== 1'b1 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
      bad++; $display("[TB] FAIL clr_absorbed: ready=%b/%b busy=%b/%b, wanted ready 1/1 busy 0/0", ready1, ready2, busy1, busy2);
    end
    doRead(8'd5, 16'h0000);
  endtask

  task automatic test_reset_mid_clear();
    int r1;
    int r2;
    doWrite(8'd0, 16'hBEEF, 2'b11);
    doWrite(8'd200, 16'h1111, 2'b11);
    doRead(8'd0, 16'hBEEF);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dout1 !== 16'h0000 || dout2 !== 16'h0000 || ready1 !== 1'b0 || ready2 !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_idle: dout=%h/%h ready=%b/%b, wanted 0000/0000 0/0", dout1, dout2, ready1, ready2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    total++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
      bad++; $display("[TB] FAIL rst_mid_busy_before: %b/%b, wanted 1/1", busy1, busy2);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0 || ready1 !== 1'b0 || ready2 !== 1'b0 || rvalid1 !== 1'b0 || rvalid2 !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_mid_outputs: busy=%b/%b ready=%b/%b rvalid=%b/%b, wanted all 0", busy1, busy2, ready1, ready2, rvalid1, rvalid2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    r1 = -1;
    r2 = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (ready1 === 1'b1 && r1 < 0) r1 = n;
      if (ready2 === 1'b1 && r2 < 0) r2 = n;
      if (r1 >= 0 && r2 >= 0) break;
    end
    total += 2;
    if (r1 != DEPTH) begin
      bad++; $display("[TB] FAIL rst_mid_len_lat1: ready after %0d cycles, wanted %0d", r1, DEPTH);
    end
    if (r2 != DEPTH) begin
      bad++; $display("[TB] FAIL rst_mid_len_lat2: ready after %0d cycles, wanted %0d", r2, DEPTH);
    end
    doRead(8'd0, 16'h0000);
    doRead(8'd200, 16'h0000);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    test_reset();
    test_byte_write();
    test_write_read_next();
    test_back_to_back();
    test_clear_collision();
    test_reset_mid_clear();
    repeat (4) @(negedge clk);
    total++;
    if (q1.size() != 0 || q2.size() != 0) begin
      bad++; $display("[TB] FAIL sb_leftover: %0d/%0d reads outstanding, wanted 0/0", q1.size(), q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
